// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag indices, state type and single-cycle ALU function
// Contents:
//   alu_op_e       3-bit op codes (001 is reserved and executes as PASS_B)
//   exec_state_e   execute-stage FSM states
//   FLAG_*         bit positions inside the 4-bit {N,Z,C,V} flag vector
//   nz_flags()     assembles the flag vector from a result plus C and V
//   alu_compute()  combinational datapath for every op that finishes in one cycle
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        OP_PASS_B = 3'b000,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110,
        OP_MUL    = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_e;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] result;
        logic [3:0]               flags;
    } alu_out_t;

    function automatic logic [3:0] nz_flags(input logic [DEFAULT_WIDTH-1:0] r,
                                            input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = r[DEFAULT_WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    function automatic alu_out_t alu_compute(input logic [2:0] op,
                                             input logic [DEFAULT_WIDTH-1:0] a,
                                             input logic [DEFAULT_WIDTH-1:0] b);
        logic [DEFAULT_WIDTH:0]   sum;
        logic [DEFAULT_WIDTH-1:0] bx;
        logic [DEFAULT_WIDTH-1:0] r;
        logic                     c;
        logic                     v;
        alu_out_t                 o;
        sum = '0;
        bx  = b;
        r   = b;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                // SUB reuses the adder as A + ~B + 1 so C reads as "no borrow"
                bx  = (op == OP_SUB) ? ~b : b;
                sum = {1'b0, a} + {1'b0, bx} + {{DEFAULT_WIDTH{1'b0}}, (op == OP_SUB)};
                r   = sum[DEFAULT_WIDTH-1:0];
                c   = sum[DEFAULT_WIDTH];
                v   = (a[DEFAULT_WIDTH-1] == bx[DEFAULT_WIDTH-1]) &&
                      (r[DEFAULT_WIDTH-1] != a[DEFAULT_WIDTH-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            // Only reached when the multiplier is not built: result 0, flags 0100
            OP_MUL:  r = '0;
            default: r = b;
        endcase
        o.result = r;
        o.flags  = nz_flags(r, c, v);
        return o;
    endfunction

endpackage

// File: rtl/alu_exec_mul.sv
// rtl/alu_exec_mul.sv - iterative shift-add multiplier, one partial product per cycle
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   start         pulse: latch a/b and begin (only asserted while idle)
//   a, b          unsigned operands
//   done          high during the cycle that processes the last bit of b
//   product       full 2*WIDTH product, valid while done is high
module alu_exec_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt;
    logic               running;

    assign acc_next = b_reg[cnt] ? acc + ({{WIDTH{1'b0}}, a_reg} << cnt) : acc;

    // The final sum is exposed combinationally so the stage can register it
    // on the same edge as the last iteration, keeping the latency at WIDTH.
    assign done    = running && (cnt == LAST);
    assign product = acc_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: 1-cycle ALU ops plus optional iterative MUL
// Build option: define ALU_EXEC_MUL_EN to instantiate the multiplier; without it
// op 111 finishes in one cycle with result 0 and flags 0100, and busy stays 0.
// Ports:
//   clk, reset_n                      clock and asynchronous active-low reset
//   in_valid/in_ready                 operation handshake from the decoder
//   in_op, in_a, in_b, in_tag         operation, operands, destination tag
//   out_valid/out_ready               result handshake to writeback
//   out_result, out_tag, out_flags    registered result, tag and {N,Z,C,V}
//   busy                              high while a multiply is iterating
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic             busy
);

    exec_state_e        state;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [TAG_W-1:0]   mul_tag;
    alu_out_t           alu_res;

    // No skid buffer: accept only when the output register is empty or draining now.
    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign alu_res  = alu_compute(in_op, in_a, in_b);

`ifdef ALU_EXEC_MUL_EN
    assign mul_start = accept && (in_op == OP_MUL);

    alu_exec_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_start   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
            mul_tag    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        // Any previous result drains on this edge (ready rule)
                        state     <= ST_MUL;
                        busy      <= 1'b1;
                        mul_tag   <= in_tag;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid  <= 1'b1;
                        out_result <= alu_res.result;
                        out_tag    <= in_tag;
                        out_flags  <= alu_res.flags;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    // Output register is empty here, so completion never waits
                    if (mul_done) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        out_result <= mul_product[WIDTH-1:0];
                        out_tag    <= mul_tag;
                        out_flags  <= nz_flags(mul_product[WIDTH-1:0],
                                               |mul_product[2*WIDTH-1:WIDTH],
                                               |mul_product[2*WIDTH-1:WIDTH]);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_tag;
    logic [3:0]  out_flags;
    logic        busy;

    int tests = 0;
    int fails = 0;

`ifdef ALU_EXEC_MUL_EN
    localparam int MUL_OFF  = 16;
    localparam int MUL_BUSY = 16;
`else
    localparam int MUL_OFF  = 0;
    localparam int MUL_BUSY = 0;
`endif

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [3:0]  f;
        int          off;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the architectural rules
    function automatic logic [19:0] ref_model(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        longint ua, ub, full;
        int sa, sb, s;
        logic [15:0] r;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        full = 0; s = 0; r = b; c = 1'b0; v = 1'b0;
        case (op)
            3'd2: begin
                full = ua + ub; r = full[15:0]; c = (full > 65535);
                s = sa + sb; v = (s > 32767) || (s < -32768);
            end
            3'd3: begin
                r = a - b; c = (ua >= ub);
                s = sa - sb; v = (s > 32767) || (s < -32768);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            3'd7: begin
`ifdef ALU_EXEC_MUL_EN
                full = ua * ub; r = full[15:0]; c = (full > 65535); v = c;
`else
                r = 16'h0000;
`endif
            end
            default: r = b;
        endcase
        return {r[15], (r == 16'h0000), c, v, r};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One full transaction: accept, wait for the result, optionally stall it.
    task automatic do_op(input string name, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] tag, input int hold,
                         input logic [15:0] exp_r, input logic [3:0] exp_f, input int exp_off,
                         input int exp_busy);
        int off, bcnt, waitc;
        logic [15:0] r0;
        logic [2:0]  t0;
        logic [3:0]  f0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            step();
            waitc++;
        end
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        off = 0; bcnt = 0;
        while (!out_valid && off < 40) begin
            if (busy) bcnt++;
            step();
            off++;
        end
        check({name, " result"}, 32'(out_result), 32'(exp_r));
        check({name, " flags"}, 32'(out_flags), 32'(exp_f));
        check({name, " tag"}, 32'(out_tag), 32'(tag));
        check({name, " valid_offset"}, 32'(off), 32'(exp_off));
        check({name, " busy_cycles"}, 32'(bcnt), 32'(exp_busy));
        r0 = out_result; t0 = out_tag; f0 = out_flags;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            step();
            check({name, " hold_stable"}, {12'h0, out_valid, r0, t0}, {12'h0, 1'b1, out_result, out_tag});
            check({name, " hold_flags"}, 32'(out_flags), 32'(f0));
            check({name, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] m;
        logic [2:0]  op;
        logic [15:0] a, b;

        reset_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = 16'h0; in_b = 16'h0;
        in_tag = 3'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_result", 32'(out_result), 32'd0);
        check("reset out_tag", 32'(out_tag), 32'd0);
        check("reset out_flags", 32'(out_flags), 32'd0);
        reset_n = 1'b1;
        step();
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        // {op, a, b, expected result, expected {N,Z,C,V}, valid offset after accept}
        vecs.push_back('{3'd2, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 0});
        vecs.push_back('{3'd2, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 0});
        vecs.push_back('{3'd2, 16'h8000, 16'h8000, 16'h0000, 4'b0111, 0});
        vecs.push_back('{3'd2, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 0});
        vecs.push_back('{3'd3, 16'hAAAA, 16'hCCCC, 16'hDDDE, 4'b1000, 0});
        vecs.push_back('{3'd3, 16'hCCAA, 16'hCCAA, 16'h0000, 4'b0110, 0});
        vecs.push_back('{3'd3, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 0});
        vecs.push_back('{3'd6, 16'hAAAA, 16'h5555, 16'hFFFF, 4'b1000, 0});
        vecs.push_back('{3'd4, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 0});
        vecs.push_back('{3'd5, 16'h8000, 16'h0001, 16'h8001, 4'b1000, 0});
        vecs.push_back('{3'd0, 16'h1234, 16'h0000, 16'h0000, 4'b0100, 0});
        vecs.push_back('{3'd1, 16'hFFFF, 16'h8001, 16'h8001, 4'b1000, 0});
`ifdef ALU_EXEC_MUL_EN
        vecs.push_back('{3'd7, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 16});
        vecs.push_back('{3'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0011, 16});
        vecs.push_back('{3'd7, 16'h0000, 16'hFFFF, 16'h0000, 4'b0100, 16});
`else
        vecs.push_back('{3'd7, 16'h0003, 16'h0005, 16'h0000, 4'b0100, 0});
        vecs.push_back('{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 0});
`endif
        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 3'(i), 0,
                  vecs[i].r, vecs[i].f, vecs[i].off, (vecs[i].off == 16) ? 16 : 0);
        end

        // Randomized ops with random output stalls
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            m = ref_model(op, a, b);
            do_op($sformatf("rnd%0d op%0d", i, op), op, a, b, 3'($urandom), $urandom_range(0, 2),
                  m[15:0], m[19:16], (op == 3'd7) ? MUL_OFF : 0, (op == 3'd7) ? MUL_BUSY : 0);
        end

        out_ready = 1'b1;
        in_valid = 1'b0;
        step();
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure: XOR result held 3 cycles, pending AND enters as it drains
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd6; in_a = 16'hAAAA; in_b = 16'h5555; in_tag = 3'd5;
        step();
        in_op = 3'd4; in_a = 16'h0F0F; in_b = 16'h00FF; in_tag = 3'd6;
        check("bp xor flags", 32'(out_flags), 32'b1000);
        for (int h = 0; h < 3; h++) begin
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp held", {12'h0, out_valid, out_result, out_tag}, {12'h0, 1'b1, 16'hFFFF, 3'd5});
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp and result", {12'h0, out_valid, out_result, out_tag}, {12'h0, 1'b1, 16'h000F, 3'd6});
        step();
        check("bp final drain", 32'(out_valid), 32'd0);

        // Throughput: 8 back-to-back ADDs
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_op = 3'd2; in_a = 16'(i * 257 + 16'h7FF0); in_b = 16'(i + 1);
            in_tag = 3'(i);
            m = ref_model(3'd2, in_a, in_b);
            check($sformatf("tp%0d in_ready", i), 32'(in_ready), 32'd1);
            step();
            check($sformatf("tp%0d out", i), {9'h0, out_valid, out_tag, out_result},
                  {9'h0, 1'b1, 3'(i), m[15:0]});
            check($sformatf("tp%0d flags", i), 32'(out_flags), 32'(m[19:16]));
        end
        in_valid = 1'b0;
        step();
        check("tp drain", 32'(out_valid), 32'd0);

        // Reset in the middle of work; nothing may survive it
`ifdef ALU_EXEC_MUL_EN
        in_valid = 1'b1; in_op = 3'd7; in_a = 16'h1234; in_b = 16'h0011; in_tag = 3'd3;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        check("mid-mul busy", 32'(busy), 32'd1);
`else
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd7; in_a = 16'h0003; in_b = 16'h0005; in_tag = 3'd3;
        step();
        in_valid = 1'b0;
        check("pre-reset pending", 32'(out_valid), 32'd1);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (20) begin
            step();
            check("post-reset no result", {30'h0, out_valid, busy}, 32'd0);
        end
        do_op("post-reset add", 3'd2, 16'h0001, 16'h0001, 3'd4, 0, 16'h0002, 4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the instruction decoder and wrapping the 16-bit combinational ALU datapath.
- Accepts one operation per handshake, registers the result with N/Z/C/V flags, and presents it to writeback over a valid/ready interface.
- Single-cycle ops: PASS_B, ADD, SUB, AND, OR, XOR. Multi-cycle op: MUL, an iterative 16x16 shift-add.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- TAG_W, 3, width of the destination-register tag carried alongside the result.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoder presents an operation.
- in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
- in_op  input  3  000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MUL, 001 reserved.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  writeback consumes; transfer occurs when out_valid && out_ready at a rising edge.
- out_result  output  WIDTH  registered result.
- out_tag  output  TAG_W  tag of out_result.
- out_flags  output  4  {N,Z,C,V} for out_result.
- busy  output  1  high while in state MUL.

Behaviour:
- Reset, asynchronous (reset_n low):
  - state = IDLE.
  - out_valid, out_result, out_tag, out_flags, busy = 0.
  - Multiplier accumulator and counter cleared.
  - Assertion mid-MUL aborts the operation; no result is produced.
- Ready rule: in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational on out_ready. There is no skid buffer.
- Single-cycle op accepted at edge k:
  - out_valid = 1 after edge k, with out_result, out_tag and out_flags loaded.
  - Latency is 1.
- Back-to-back accepts are allowed when downstream holds out_ready = 1, giving a throughput of 1 per cycle.
- Hold rule: while out_valid && !out_ready, out_result, out_tag and out_flags are stable and in_ready = 0.
- Drain: when out_valid && out_ready and no new accept occurs, out_valid = 0 at the next edge.
- Arithmetic:
  - ADD = A + B, with carry-in 0.
  - SUB = A + ~B + 1; C = 1 means no borrow.
  - Results wrap modulo 2^16.
- Flags:
  - N = result[15].
  - Z = (result == 0).
  - ADD/SUB: C = carry out of bit 15; V = signed overflow (operand signs equal and result sign differs, where the operands are A and B for ADD, and A and ~B for SUB).
  - PASS_B, AND, OR, XOR: C = V = 0.
  - MUL: C = V = (upper 16 bits of the 32-bit unsigned product != 0).
- Reserved op 001: treated as PASS_B.
- MUL state machine:
  - Entry: IDLE -> MUL on accept with in_op = 111. Latch a, b and tag; acc = 0; cnt = 0; busy = 1.
  - MUL state, each cycle: if b[cnt], acc += a << cnt (32-bit accumulator); then cnt++.
  - Exit: after the 16th iteration (cnt == 15 processed), return to IDLE. out_valid = 1 with out_result = acc[15:0] and out_flags derived from the 32-bit acc.
  - Latency: accept at edge k gives out_valid after edge k+16.
  - in_ready = 0 throughout the MUL state.
  - The output register is guaranteed empty at MUL completion (ready rule), so no wait state is needed.
- Operands equal to 0 or 0xFFFF are not special-cased; the MUL latency is always 16.

Optional Feature:
- ALU_EXEC_MUL_EN, defined:
  - MUL is implemented as above and the multiplier sub-module is instantiated.
- ALU_EXEC_MUL_EN, undefined:
  - No multiplier hardware; busy is tied 0.
  - op 111 completes with single-cycle latency: out_result = 0, flags {N,Z,C,V} = 0100.
  - out_tag passes through normally.

Decomposition:
- Shared package alu_pkg:
  - op-code enum (PASS_B, ADD, SUB, AND, OR, XOR, MUL).
  - flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - state enum {IDLE, MUL}.
  - WIDTH default 16.
- One sub-module, alu_exec_mul: iterative shift-add multiplier with start/done, a 32-bit product and a 4-bit counter. It exists only under ALU_EXEC_MUL_EN.

Test Plan:
- Reset mid-operation: assert reset_n = 0 during MUL cycle 8 -> out_valid = 0 and busy = 0 immediately; state IDLE after release; the next ADD 1+1 yields 0x0002 with latency 1.
- ADD boundary: ADD 0x7FFF+0x0001 -> 0x8000, flags N=1, Z=0, C=0, V=1. ADD 0xFFFF+0x0001 -> 0x0000, flags Z=1, C=1, V=0. Each with out_valid exactly 1 cycle after accept.
- SUB: 0xAAAA-0xCCCC -> 0xDDDE, C=0, N=1. 0xCCAA-0xCCAA -> 0x0000, Z=1, C=1.
- Backpressure: out_ready = 0 for 3 cycles after an XOR 0xAAAA^0x5555 result (0xFFFF, N=1) -> result and tag stable, in_ready = 0; on release the pending AND is accepted the same cycle the result drains.
- MUL: 0x0003*0x0005 -> 0x000F, C=V=0, out_valid at accept+16, busy high for 16 cycles. 0xFFFF*0xFFFF -> 0x0001, C=V=1.
- Throughput: 8 back-to-back ADDs with out_ready held 1 -> 8 results on 8 consecutive cycles with tags in order. With the macro undefined, MUL 3*5 -> 0x0000, flags 0100, latency 1.
